instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Sequential RV32I instruction encoder and loader: the encode-side counterpart of the core's main control decoder.
- Accepts instruction fields over a valid/ready handshake, checks them against the instruction subset the control decoder supports, packs them into 32-bit words, and writes them to consecutive instruction-memory word addresses.
- Used by boot/self-test logic to populate instruction memory before the core is released.

Parameters:
ADDR_W, 8, width of the imem word address and of the count.
DEPTH, 256, number of words that may be loaded; must be at most 2^ADDR_W.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous restart: address and count to 0, err cleared
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept the bundle this cycle
in_kind  in  4  0 LW, 1 SW, 2 R, 3 BR, 4 OPIMM, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal
in_funct3  in  3  funct3, used for R, BR and OPIMM only
in_funct7b5  in  1  sub/sra/srai select
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  signed immediate; for U-type, the value placed in bits 31:12
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written since reset/clear
full  out  1  count == DEPTH
err  out  1  sticky; set when any bundle is rejected
err_code  out  3  reason for the most recent rejection

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM enters LOAD; any pending write is discarded.
- FSM states:
  - LOAD: in_ready = !clear.
  - FULL: in_ready = 0.
  - LOAD -> FULL when an accepted legal bundle makes count reach DEPTH.
  - Any state -> LOAD on clear.
- Handshake: a transfer occurs on a clock edge with in_valid && in_ready. Field inputs are sampled only at that edge.
- Latency is 1: on the cycle after acceptance, imem_we = 1 with imem_wdata = the encoded word and imem_addr = the pre-increment address. Address and count increment at that same edge.
- Back-to-back transfers are allowed, giving one word per cycle. imem_we is 0 in any cycle that follows no legal acceptance.
- imem_addr holds its last value while idle. imem_wdata holds its last value.
- Opcodes and fixed fields:
  - LW: 0000011, funct3 010. SW: 0100011, funct3 010.
  - R: 0110011. BR: 1100011. OPIMM: 0010011.
  - JAL: 1101111. JALR: 1100111, funct3 000.
  - LUI: 0110111. AUIPC: 0010111.
- Formats:
  - I (LW, JALR, OPIMM except shifts): imm[11:0] in bits 31:20.
  - S: imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - U: imm[31:12] in bits 31:12, rd, opcode.
  - R: funct7 = {0, funct7b5, 00000}.
  - Shifts (OPIMM, funct3 001 or 101): bits 31:25 = {0, funct7b5, 00000}, shamt = imm[4:0].
- Legality checks (err_code):
  - 1: illegal kind.
  - 2: unsupported funct3. OPIMM allows 000, 001, 011, 100, 101. BR allows 000, 001, 100, 101, 110, 111.
  - 3: funct7b5 = 1 with an R funct3 other than 000/101, with OPIMM funct3 001, or with OPIMM funct3 other than 001/101.
  - 4: immediate out of range. I/S need -2048..2047, B needs -4096..4094, J needs -2^20..2^20-2, shamt needs 0..31.
  - 5: B or J immediate is odd.
- Rejected bundle: it is still accepted (handshake completes), so a bad bundle never stalls the producer. No write occurs, address and count are unchanged, err is set, and err_code is updated.
- Check priority when several rules fail: 1 > 2 > 3 > 4 > 5.
- clear together with in_valid: clear wins and the bundle is not accepted. A write already scheduled for the cycle clear is high still completes, but address/count finish at 0.
- count saturates at DEPTH; addresses never wrap.

Test Plan:
- Reset, then addi x1,x0,5 (kind 4, f3 000, imm 5) -> next cycle imem_we=1, addr 0, wdata 0x00500093; count=1.
- Back-to-back sub x3,x1,x2 then beq x1,x2,-4 -> 0x402081B3 @0 and 0xFE208EE3 @1 on consecutive cycles; in_ready stays 1.
- jal x1,2048, then lui x5,0x12345 (in_imm 0x12345000) -> 0x001000EF and 0x123452B7.
- Branch with imm 3 -> no imem_we; err=1, err_code=5; address unchanged; the next legal bundle is written to the same address.
- DEPTH=4: four legal bundles -> full=1, in_ready=0; a fifth held valid is not accepted; clear -> count 0, in_ready=1.
- Assert reset_n low the cycle after acceptance -> imem_we stays 0 and all outputs are 0 asynchronously.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder: packs legal bundles into 32-bit words and streams them to
// consecutive instruction-memory addresses; illegal bundles are consumed and flagged.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int unsigned     CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [3:0] KindLw    = 4'd0;
  localparam logic [3:0] KindSw    = 4'd1;
  localparam logic [3:0] KindR     = 4'd2;
  localparam logic [3:0] KindBr    = 4'd3;
  localparam logic [3:0] KindOpImm = 4'd4;
  localparam logic [3:0] KindJal   = 4'd5;
  localparam logic [3:0] KindJalr  = 4'd6;
  localparam logic [3:0] KindLui   = 4'd7;
  localparam logic [3:0] KindAuipc = 4'd8;

  typedef enum logic [0:0] {StLoad, StFull} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [2:0]         code_q, code_d;

  logic signed [31:0] imm_s;
  logic               i_ok, b_ok, j_ok, sh_ok, is_shift;
  logic [6:0]         funct7;
  logic [31:0]        word;
  logic [2:0]         code;
  logic               kind_bad, f3_bad, f7_bad, range_bad, odd_bad;
  logic               accept;

  assign imm_s    = $signed(in_imm);
  assign i_ok     = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign b_ok     = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
  assign j_ok     = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
  assign sh_ok    = (in_imm[31:5] == 27'd0);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign funct7   = {1'b0, in_funct7b5, 5'b00000};

  always_comb begin
    word      = 32'd0;
    kind_bad  = 1'b0;
    f3_bad    = 1'b0;
    f7_bad    = 1'b0;
    range_bad = 1'b0;
    odd_bad   = 1'b0;
    case (in_kind)
      KindLw: begin
        word      = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        range_bad = !i_ok;
      end
      KindSw: begin
        word      = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        range_bad = !i_ok;
      end
      KindR: begin
        word   = {funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        f7_bad = in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
      end
      KindBr: begin
        word      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                     in_imm[11], 7'b1100011};
        f3_bad    = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
        range_bad = !b_ok;
        odd_bad   = in_imm[0];
      end
      KindOpImm: begin
        word      = is_shift ? {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011}
                             : {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        f3_bad    = (in_funct3 == 3'b010) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        // Only srai may carry funct7b5.
        f7_bad    = in_funct7b5 && (in_funct3 != 3'b101);
        range_bad = is_shift ? !sh_ok : !i_ok;
      end
      KindJal: begin
        word      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        range_bad = !j_ok;
        odd_bad   = in_imm[0];
      end
      KindJalr: begin
        word      = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        range_bad = !i_ok;
      end
      KindLui:   word = {in_imm[31:12], in_rd, 7'b0110111};
      KindAuipc: word = {in_imm[31:12], in_rd, 7'b0010111};
      default:   kind_bad = 1'b1;
    endcase

    if (kind_bad)       code = 3'd1;
    else if (f3_bad)    code = 3'd2;
    else if (f7_bad)    code = 3'd3;
    else if (range_bad) code = 3'd4;
    else if (odd_bad)   code = 3'd5;
    else                code = 3'd0;
  end

  // Ready is forced low while in reset so every output reads 0.
  assign in_ready = reset_n && (state_q == StLoad) && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    code_d  = code_q;
    if (clear) begin
      state_d = StLoad;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = 3'd0;
    end else if (accept) begin
      if (code == 3'd0) begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = word;
        if (count_q != DepthCnt) count_d = count_q + 1'b1;
        if (count_q == DepthCnt - 1'b1) state_d = StFull;
      end else begin
        err_d  = 1'b1;
        code_d = code;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StLoad;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (count_q == DepthCnt);
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized bundles checked
// against an instruction-level reference model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_kind = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_funct7b5 = 1'b0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, err;
  logic [2:0]        err_code;

  int errors = 0;
  int checks = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count), .full(full), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fld(input int v, input int hi, input int lo);
    logic [31:0] u;
    u = v;
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic int ref_code(input int k, input int f3, input int f7, input int imm);
    int lo, hi;
    bit chk;
    if (k > 8) return 1;
    if (k == 4 && (f3 == 2 || f3 == 6 || f3 == 7)) return 2;
    if (k == 3 && (f3 == 2 || f3 == 3)) return 2;
    if (f7 != 0 && k == 2 && f3 != 0 && f3 != 5) return 3;
    if (f7 != 0 && k == 4 && f3 != 5) return 3;
    chk = 1; lo = -2048; hi = 2047;
    if (k == 4 && (f3 == 1 || f3 == 5)) begin lo = 0; hi = 31; end
    else if (k == 3) begin lo = -4096; hi = 4094; end
    else if (k == 5) begin lo = -(1 << 20); hi = (1 << 20) - 2; end
    else if (k == 2 || k == 7 || k == 8) chk = 0;
    if (chk && (imm < lo || imm > hi)) return 4;
    if ((k == 3 || k == 5) && (imm & 1) != 0) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] ref_word(input int k, input int f3, input int f7, input int rd,
                                           input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    logic [31:0] regs;
    regs = (rd << 7) | (rs1 << 15);
    case (k)
      0: w = (fld(imm, 11, 0) << 20) | regs | (2 << 12) | 32'h03;
      1: w = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
             | (fld(imm, 4, 0) << 7) | 32'h23;
      2: w = (f7 << 30) | (rs2 << 20) | regs | (f3 << 12) | 32'h33;
      3: w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
             | (f3 << 12) | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
      4: if (f3 == 1 || f3 == 5) w = (f7 << 30) | (fld(imm, 4, 0) << 20) | regs | (f3 << 12) | 32'h13;
         else w = (fld(imm, 11, 0) << 20) | regs | (f3 << 12) | 32'h13;
      5: w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
             | (fld(imm, 19, 12) << 12) | (rd << 7) | 32'h6F;
      6: w = (fld(imm, 11, 0) << 20) | regs | 32'h67;
      7: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
      default: w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
    endcase
    return w;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input int k, input int f3, input int f7, input int rd, input int rs1,
                       input int rs2, input int imm);
    in_valid = 1'b1; in_kind = 4'(k); in_funct3 = 3'(f3); in_funct7b5 = 1'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); idle(); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", in_ready); end
    checks++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_imem we=%b addr=%h wdata=%h want 0", imem_we, imem_addr, imem_wdata); end
    checks++; if (count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 3'd0) begin
      errors++; $display("FAIL reset_status cnt=%0d full=%b err=%b code=%0d want 0", count, full, err, err_code); end
    @(negedge clk); reset_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_addi();
    @(negedge clk); drive(4, 0, 0, 1, 0, 0, 5);
    @(negedge clk); idle();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'h00500093) begin
      errors++; $display("FAIL addi_write we=%b addr=%0d wdata=%h want 1/0/00500093", imem_we, imem_addr, imem_wdata); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL addi_count got=%0d want=1", count); end
    @(negedge clk);
    checks++; if (imem_we !== 1'b0 || imem_wdata !== 32'h00500093) begin
      errors++; $display("FAIL addi_idle we=%b wdata=%h want 0/00500093", imem_we, imem_wdata); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    drive(2, 0, 1, 3, 1, 2, 0);
    @(negedge clk);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'h402081B3) begin
      errors++; $display("FAIL b2b_sub we=%b addr=%0d wdata=%h want 1/0/402081B3", imem_we, imem_addr, imem_wdata); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
    drive(3, 0, 0, 0, 1, 2, -4);
    @(negedge clk); idle();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1 || imem_wdata !== 32'hFE208EE3) begin
      errors++; $display("FAIL b2b_beq we=%b addr=%0d wdata=%h want 1/1/FE208EE3", imem_we, imem_addr, imem_wdata); end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got=%0d want=2", count); end
  endtask

  task automatic test_jal_lui();
    do_clear();
    drive(5, 0, 0, 1, 0, 0, 2048);
    @(negedge clk);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'h001000EF) begin
      errors++; $display("FAIL jal_write we=%b addr=%0d wdata=%h want 1/0/001000EF", imem_we, imem_addr, imem_wdata); end
    drive(7, 0, 0, 5, 0, 0, 32'h12345000);
    @(negedge clk); idle();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1 || imem_wdata !== 32'h123452B7) begin
      errors++; $display("FAIL lui_write we=%b addr=%0d wdata=%h want 1/1/123452B7", imem_we, imem_addr, imem_wdata); end
  endtask

  task automatic test_bad_branch();
    // count is 2 here; an odd branch offset is rejected without a write.
    @(negedge clk); drive(3, 0, 0, 0, 1, 2, 3);
    @(negedge clk); idle();
    checks++; if (imem_we !== 1'b0 || count !== 3'd2) begin
      errors++; $display("FAIL odd_br_nowrite we=%b cnt=%0d want 0/2", imem_we, count); end
    checks++; if (err !== 1'b1 || err_code !== 3'd5) begin
      errors++; $display("FAIL odd_br_err err=%b code=%0d want 1/5", err, err_code); end
    drive(4, 0, 0, 2, 0, 0, 7);
    @(negedge clk);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd2 || imem_wdata !== 32'h00700113) begin
      errors++; $display("FAIL after_err_write we=%b addr=%0d wdata=%h want 1/2/00700113", imem_we, imem_addr, imem_wdata); end
    // funct3 010 and an odd offset: funct3 reason outranks oddness.
    drive(3, 2, 0, 0, 1, 2, 3);
    @(negedge clk); idle();
    checks++; if (err !== 1'b1 || err_code !== 3'd2 || count !== 3'd3) begin
      errors++; $display("FAIL priority err=%b code=%0d cnt=%0d want 1/2/3", err, err_code, count); end
    do_clear();
    checks++; if (err !== 1'b0 || err_code !== 3'd0 || count !== 3'd0) begin
      errors++; $display("FAIL clear_err err=%b code=%0d cnt=%0d want 0/0/0", err, err_code, count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(4, 0, 0, i + 1, 0, 0, i);
      @(negedge clk);
      checks++; if (imem_we !== 1'b1 || imem_addr !== 2'(i) || imem_wdata !== ref_word(4, 0, 0, i + 1, 0, 0, i)) begin
        errors++; $display("FAIL fill_%0d we=%b addr=%0d wdata=%h", i, imem_we, imem_addr, imem_wdata); end
    end
    drive(4, 0, 0, 9, 0, 0, 9);
    checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL full_flag full=%b rdy=%b cnt=%0d want 1/0/4", full, in_ready, count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem_we !== 1'b0 || count !== 3'd4) begin
        errors++; $display("FAIL full_hold we=%b cnt=%0d want 0/4", imem_we, count); end
    end
    clear = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b want=0", in_ready); end
    @(negedge clk); clear = 1'b0; #1;
    checks++; if (count !== 3'd0 || full !== 1'b0 || in_ready !== 1'b1 || imem_we !== 1'b0) begin
      errors++; $display("FAIL after_clear cnt=%0d full=%b rdy=%b we=%b want 0/0/1/0", count, full, in_ready, imem_we); end
    // A write already scheduled when clear rises still completes.
    @(negedge clk);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd0 || count !== 3'd1) begin
      errors++; $display("FAIL held_accept we=%b addr=%0d cnt=%0d want 1/0/1", imem_we, imem_addr, count); end
    idle(); drive(4, 0, 0, 2, 0, 0, 1);
    @(negedge clk); idle(); clear = 1'b1;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1) begin
      errors++; $display("FAIL sched_write we=%b addr=%0d want 1/1", imem_we, imem_addr); end
    @(negedge clk); clear = 1'b0;
    checks++; if (count !== 3'd0 || imem_we !== 1'b0) begin
      errors++; $display("FAIL sched_clear cnt=%0d we=%b want 0/0", count, imem_we); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(4, 0, 0, 1, 0, 0, 5);
    @(posedge clk); #1; reset_n = 1'b0; idle(); #1;
    checks++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 || count !== '0) begin
      errors++; $display("FAIL async_reset we=%b addr=%0d wdata=%h cnt=%0d want 0", imem_we, imem_addr, imem_wdata, count); end
    checks++; if (in_ready !== 1'b0 || full !== 1'b0 || err !== 1'b0 || err_code !== 3'd0) begin
      errors++; $display("FAIL async_reset_status rdy=%b full=%b err=%b code=%0d want 0", in_ready, full, err, err_code); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_we !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL reset_discard we=%b cnt=%0d want 0/0", imem_we, count); end
  endtask

  task automatic test_random();
    int bnd[16] = '{-4097, -4096, -2049, -2048, 0, 31, 32, 2047, 2048, 4094, 4095,
                    1048574, 1048575, 1048576, -1048576, -1048578};
    int m_count = 0, m_code = 0, m_addr = 0;
    bit m_err = 0, m_we = 0;
    logic [31:0] m_wdata = 32'd0;
    for (int it = 0; it < 500; it++) begin
      int r, k, f3, f7, rd, rs1, rs2, imm, c;
      bit clr, vld, acc;
      r   = $urandom_range(0, 15);
      clr = (r == 0) || (m_count == DEPTH && r < 6);
      vld = (r > 2);
      k = $urandom_range(0, 10); f3 = $urandom_range(0, 7); f7 = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0: imm = $urandom_range(0, 80) - 40;
        1: imm = bnd[$urandom_range(0, 15)];
        2: imm = $urandom;
        default: imm = $urandom_range(0, 8191) - 4096;
      endcase
      drive(k, f3, f7, rd, rs1, rs2, imm);
      in_valid = vld; clear = clr; #1;
      checks++; if (in_ready !== (!clr && m_count != DEPTH)) begin
        errors++; $display("FAIL rnd_ready it=%0d got=%b want=%b", it, in_ready, !clr && m_count != DEPTH); end
      acc = vld && !clr && m_count != DEPTH;
      @(posedge clk);
      m_we = 0;
      if (clr) begin
        m_count = 0; m_err = 0; m_code = 0;
      end else if (acc) begin
        c = ref_code(k, f3, f7, imm);
        if (c == 0) begin
          m_we = 1; m_addr = m_count; m_wdata = ref_word(k, f3, f7, rd, rs1, rs2, imm); m_count++;
        end else begin
          m_err = 1; m_code = c;
        end
      end
      @(negedge clk); clear = 1'b0; idle();
      checks++; if (imem_we !== m_we || imem_wdata !== m_wdata || (m_we && imem_addr !== 2'(m_addr))) begin
        errors++; $display("FAIL rnd_write it=%0d k=%0d f3=%0d imm=%0d we=%b addr=%0d wdata=%h want %b/%0d/%h",
                           it, k, f3, imm, imem_we, imem_addr, imem_wdata, m_we, m_addr, m_wdata); end
      checks++; if (count !== 3'(m_count) || full !== (m_count == DEPTH)) begin
        errors++; $display("FAIL rnd_count it=%0d cnt=%0d full=%b want %0d", it, count, full, m_count); end
      checks++; if (err !== m_err || err_code !== 3'(m_code)) begin
        errors++; $display("FAIL rnd_err it=%0d k=%0d f3=%0d f7=%0d imm=%0d err=%b code=%0d want %b/%0d",
                           it, k, f3, f7, imm, err, err_code, m_err, m_code); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal_lui();
    test_bad_branch();
    test_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
